// File: rtl/pdm_audio_in.sv
// PDM microphone front end: clock divider, 2-flop input synchronizer, 64:1 ones-count
// decimator into a 256x16 sample ring, and a single-cycle PicoRV32 bus slave.
module pdm_audio_in #(
    parameter int CLK_DIV = 16,
    parameter int DECIM   = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable_ram,
    input  logic        enable_ctrl,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    output logic        pdm_clk_o,
    input  logic        pdm_data_i,
    output logic        irq_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
    localparam logic [5:0]    BIT_LAST = 6'(DECIM - 1);

    logic          run_q, run_d, irq_en_q, irq_en_d;
    logic          irq_pending_q, irq_pending_d, overrun_q, overrun_d;
    logic [7:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    ones_q, ones_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          mem_ready_q, mem_ready_d, pdm_clk_q, pdm_clk_d, irq_q, irq_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;

    logic [15:0]   buf_mem [0:255];
    logic [15:0]   rd_sample, smp_val;
    logic [6:0]    ones_sum;
    logic          req, ctrl_wr, run_start, run_stop, bit_tick, smp_we, set_evt, clr_irq;
    logic          unused_bits;

    assign unused_bits = ^{mem_instr, mem_addr[31:10], mem_addr[1:0], mem_wdata[31:3]};
    assign rd_sample   = buf_mem[mem_addr[9:2]];

    always_comb begin
        req       = mem_valid && (enable_ram || enable_ctrl) && !mem_ready_q;
        ctrl_wr   = req && enable_ctrl && (mem_wstrb != 4'b0);
        run_start = ctrl_wr && !run_q && mem_wdata[0];
        run_stop  = ctrl_wr && run_q && !mem_wdata[0];
        clr_irq   = ctrl_wr && mem_wdata[2];
        bit_tick  = run_q && (cnt_q == CNT_LAST) && !run_stop;

        run_d     = ctrl_wr ? mem_wdata[0] : run_q;
        irq_en_d  = ctrl_wr ? mem_wdata[1] : irq_en_q;
        cnt_d     = (!run_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        sync1_d   = pdm_data_i;
        sync2_d   = sync1_q;
        wr_ptr_d  = wr_ptr_q;
        ones_d    = ones_q;
        bit_cnt_d = bit_cnt_q;
        smp_we    = 1'b0;
        set_evt   = 1'b0;

        // (ones-32)<<10 in 16 bits: subtracting 32 only flips bit 5 of the 6-bit count
        ones_sum = ones_q + 7'(sync2_q);
        smp_val  = ones_sum[6] ? 16'h7FFF : {~ones_sum[5], ones_sum[4:0], 10'b0};

        if (bit_tick) begin
            if (bit_cnt_q == BIT_LAST) begin
                smp_we    = 1'b1;
                set_evt   = (wr_ptr_q[6:0] == 7'h7F);
                wr_ptr_d  = wr_ptr_q + 8'd1;
                ones_d    = '0;
                bit_cnt_d = '0;
            end else begin
                ones_d    = ones_sum;
                bit_cnt_d = bit_cnt_q + 6'd1;
            end
        end

        if (run_start || run_stop) begin
            cnt_d     = '0;
            ones_d    = '0;
            bit_cnt_d = '0;
        end
        if (run_start) wr_ptr_d = '0;

        irq_pending_d = set_evt || (irq_pending_q && !clr_irq);
        overrun_d     = clr_irq ? 1'b0 : (overrun_q || (set_evt && irq_pending_q));

        pdm_clk_d   = run_d && (cnt_d < CNT_HALF);
        irq_d       = irq_pending_d && irq_en_d;
        mem_ready_d = req;
        mem_rdata_d = '0;
        if (req && mem_wstrb == 4'b0) begin
            if (enable_ctrl)
                mem_rdata_d = {14'b0, overrun_q, irq_pending_q, wr_ptr_q, 6'b0, irq_en_q, run_q};
            else
                mem_rdata_d = {{16{rd_sample[15]}}, rd_sample};
        end
    end

    // Sample store has no reset; a CPU read in the same cycle sees the previous contents.
    always_ff @(posedge clk) begin
        if (smp_we) buf_mem[wr_ptr_q] <= smp_val;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q         <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_pending_q <= 1'b0;
            overrun_q     <= 1'b0;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            ones_q        <= '0;
            bit_cnt_q     <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            mem_ready_q   <= 1'b0;
            mem_rdata_q   <= '0;
            pdm_clk_q     <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            run_q         <= run_d;
            irq_en_q      <= irq_en_d;
            irq_pending_q <= irq_pending_d;
            overrun_q     <= overrun_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            ones_q        <= ones_d;
            bit_cnt_q     <= bit_cnt_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            mem_ready_q   <= mem_ready_d;
            mem_rdata_q   <= mem_rdata_d;
            pdm_clk_q     <= pdm_clk_d;
            irq_q         <= irq_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign pdm_clk_o = pdm_clk_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_pdm_audio_in.sv
// Directed bench for pdm_audio_in with CLK_DIV=4 (256 clk per sample).
module tb_pdm_audio_in;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable_ram = 1'b0, enable_ctrl = 1'b0, mem_valid = 1'b0, mem_instr = 1'b0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_wdata = '0, mem_addr = '0;
    logic        pdm_data_i = 1'b1;
    logic        mem_ready, pdm_clk_o, irq_o;
    logic [31:0] mem_rdata;
    int          checks = 0, failures = 0;

    pdm_audio_in #(.CLK_DIV(4), .DECIM(64)) dut (
        .clk(clk), .resetn(resetn), .enable_ram(enable_ram), .enable_ctrl(enable_ctrl),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instr(mem_instr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .pdm_clk_o(pdm_clk_o), .pdm_data_i(pdm_data_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic ram, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, output logic [31:0] rd);
        int lat;
        @(negedge clk);
        enable_ram = ram; enable_ctrl = !ram; mem_valid = 1'b1;
        mem_addr = addr; mem_wstrb = strb; mem_wdata = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_ready && lat < 8);
        rd = mem_rdata;
        mem_valid = 1'b0; enable_ram = 1'b0; enable_ctrl = 1'b0; mem_wstrb = '0;
        chk("ack_latency", 32'(lat), 32'd1);
    endtask

    task automatic rd_ctrl(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, 32'h0, 4'h0, 32'h0, d);
        chk(tag, d, exp);
    endtask

    task automatic rd_buf(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b1, 32'(idx * 4), 4'h0, 32'h0, d);
        chk(tag, d, exp);
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        logic [31:0] d;
        bus(1'b0, 32'h0, 4'hF, v, d);
    endtask

    initial begin
        int hi;
        logic [31:0] d;

        #12;
        chk("reset_outputs", {mem_rdata[30:0], mem_ready}, 32'h0);
        chk("reset_pins", {30'b0, pdm_clk_o, irq_o}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        wait_cyc(2);
        rd_ctrl("ctrl_after_reset", 32'h0);

        // no enable: no acknowledge
        hi = 0;
        mem_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            hi += int'(mem_ready);
        end
        mem_valid = 1'b0;
        chk("no_enable_no_ready", 32'(hi), 32'd0);

        // valid held past the acknowledge: exactly one ready cycle
        @(negedge clk);
        mem_valid = 1'b1; enable_ram = 1'b1; mem_addr = '0;
        @(negedge clk);
        chk("ready_pulse_hi", {31'b0, mem_ready}, 32'd1);
        @(negedge clk);
        chk("ready_pulse_lo", {31'b0, mem_ready}, 32'd0);
        mem_valid = 1'b0; enable_ram = 1'b0;

        // constant ones -> full-scale positive
        wr_ctrl(32'h1);
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            hi += int'(pdm_clk_o);
        end
        chk("pdm_clk_duty", 32'(hi), 32'd8);
        wait_cyc(254);
        rd_ctrl("ctrl_wr_ptr1", 32'h0000_0101);
        rd_buf("buf_ones", 0, 32'h0000_7FFF);
        wr_ctrl(32'h0);
        @(negedge clk);
        chk("pdm_clk_stopped", {31'b0, pdm_clk_o}, 32'd0);
        rd_ctrl("ctrl_frozen_ptr", 32'h0000_0100);
        bus(1'b1, 32'h0, 4'hF, 32'h0000_1234, d);
        rd_buf("buf_write_ignored", 0, 32'h0000_7FFF);

        // constant zeros -> full-scale negative
        pdm_data_i = 1'b0;
        wait_cyc(4);
        wr_ctrl(32'h1);
        wait_cyc(270);
        rd_buf("buf_zeros", 0, 32'hFFFF_8000);
        wr_ctrl(32'h0);

        // alternating bit per PDM period -> 32 ones -> zero
        wr_ctrl(32'h1);
        for (int i = 0; i < 272; i++) begin
            @(negedge clk);
            if (i % 4 == 0) pdm_data_i = ~pdm_data_i;
        end
        rd_buf("buf_alt", 0, 32'h0000_0000);
        rd_ctrl("ctrl_alt_ptr", 32'h0000_0101);
        wr_ctrl(32'h0);

        // interrupt at 128 samples, overrun at 256 without clearing
        pdm_data_i = 1'b1;
        wait_cyc(4);
        wr_ctrl(32'h3);
        wait_cyc(32758);
        chk("irq_before_128", {31'b0, irq_o}, 32'd0);
        wait_cyc(30);
        chk("irq_at_128", {31'b0, irq_o}, 32'd1);
        rd_ctrl("ctrl_pending_128", 32'h0001_8003);
        wait_cyc(32760);
        rd_ctrl("ctrl_overrun", 32'h0003_0003);
        rd_buf("buf_200", 200, 32'h0000_7FFF);
        chk("irq_still_high", {31'b0, irq_o}, 32'd1);
        wr_ctrl(32'h7);
        rd_ctrl("ctrl_cleared", 32'h0000_0003);
        chk("irq_cleared", {31'b0, irq_o}, 32'd0);

        // asynchronous reset in the middle of an acknowledged access while running
        hi = 0;
        while (!pdm_clk_o && hi < 8) begin
            @(negedge clk);
            hi++;
        end
        chk("pdm_clk_running", {31'b0, pdm_clk_o}, 32'd1);
        mem_valid = 1'b1; enable_ctrl = 1'b1; mem_wstrb = '0;
        @(posedge clk);
        #1;
        chk("mid_ack_ready", {31'b0, mem_ready}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("async_reset_bus", {mem_rdata[30:0], mem_ready}, 32'h0);
        chk("async_reset_pins", {30'b0, pdm_clk_o, irq_o}, 32'h0);
        wait_cyc(2);
        mem_valid = 1'b0; enable_ctrl = 1'b0;
        resetn = 1'b1;
        wait_cyc(2);
        rd_ctrl("ctrl_after_midrun_reset", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pdm_audio_in.md
PDM_AUDIO_IN -- requirements
Module: pdm_audio_in

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, clk cycles per PDM bit (even, >=4).
REQ-002 SHALL have parameter DECIM, default 64, PDM bits per output sample (fixed at 64 for the 16-bit scaling in REQ-013).
REQ-003 SHALL have ports, one clock and one asynchronous active-low reset:
 clk  in  1  system clock (50 MHz)
 resetn  in  1  asynchronous reset, active low
 enable_ram  in  1  address decode: sample buffer selected
 enable_ctrl  in  1  address decode: control/status register selected
 mem_valid  in  1  PicoRV32 bus request
 mem_ready  out  1  bus acknowledge
 mem_instr  in  1  instruction fetch flag (ignored)
 mem_wstrb  in  4  byte write strobes, nonzero = write
 mem_wdata  in  32  write data
 mem_addr  in  32  byte address; bits [9:2] index the buffer
 mem_rdata  out  32  read data
 pdm_clk_o  out  1  clock to PDM microphone
 pdm_data_i  in  1  PDM bitstream from microphone
 irq_o  out  1  interrupt to CPU, active high, level

Function
REQ-004 Bus: when mem_valid=1 and (enable_ram or enable_ctrl)=1 and mem_ready=0, mem_ready SHALL pulse high exactly one cycle, on the next clk edge.
REQ-005 mem_rdata SHALL be valid in the mem_ready cycle; otherwise 0.
REQ-006 Buffer reads SHALL return {{16{s[15]}}, s}, s = buffer[mem_addr[9:2]]; buffer writes SHALL be acknowledged and discarded.
REQ-007 Control write (any wstrb nonzero): bit0 run, bit1 irq_en; bit2=1 clears irq_pending; bits 0..1 stored.
REQ-008 Control read: {14'b0, overrun, irq_pending, wr_ptr[7:0], 5'b0, 0, irq_en, run} with overrun at bit 17, irq_pending at bit 16, wr_ptr at bits 15:8.
REQ-009 Divider cnt 0..CLK_DIV-1 SHALL run only while run=1; pdm_clk_o = 1 for cnt < CLK_DIV/2, else 0; held 0 while run=0.
REQ-010 pdm_data_i SHALL be sampled (via 2-flop synchronizer) in the cycle cnt==CLK_DIV-1.
REQ-011 Decimator SHALL count ones over DECIM sampled bits (7-bit counter, 0..64) and a bit counter 0..DECIM-1.
REQ-012 On the DECIM-th bit, the sample SHALL be written to buffer[wr_ptr], wr_ptr incremented mod 256, and both counters restarted in the same cycle (the current bit counted).
REQ-013 Sample = (2*ones - 64) << 9, saturated to 16-bit signed: ones=64 -> 0x7FFF, ones=32 -> 0x0000, ones=0 -> 0x8000.
REQ-014 Buffer SHALL be 256x16 dual-port; same-cycle CPU read and sample write to same index returns old data.
REQ-015 irq_pending SHALL set when wr_ptr advances 127->128 or 255->0; irq_o = irq_pending & irq_en.
REQ-016 If irq_pending is already 1 when a new set event occurs, overrun SHALL set; overrun clears with bit2 clear write.
REQ-017 Simultaneous set event and clear write: set wins; overrun not set.
REQ-018 Write with run 0->1 SHALL clear wr_ptr, cnt, both decimator counters; run 1->0 SHALL freeze wr_ptr and clear cnt and counters; buffer contents kept.

Reset
REQ-019 resetn=0 SHALL asynchronously clear run, irq_en, irq_pending, overrun, wr_ptr, cnt, counters, synchronizer, mem_ready, mem_rdata, pdm_clk_o, irq_o; buffer contents undefined.
REQ-020 Reset mid-transaction SHALL drop mem_ready; the request is not acknowledged.

Verification
REQ-021 Assert resetn=0 mid-run -> all outputs 0 immediately; control read after release = 0x00000000.
REQ-022 run=1, pdm_data_i=1 constant -> buffer[0] read = 0x00007FFF within 1024+4 clk; control read wr_ptr=1.
REQ-023 pdm_data_i=0 constant -> buffer[0] = 0xFFFF8000; alternating 1,0 per PDM bit -> 0x00000000.
REQ-024 irq_en=1, run=1 -> irq_o rises when wr_ptr 127->128; write 0x7 clears it; no clear through 255->0 and 127->128 -> overrun=1.
REQ-025 Any access with mem_valid=1 and one enable high -> mem_ready high exactly one cycle, next edge; mem_valid=1 with both enables low -> mem_ready stays 0.
